// File: rtl/tone_detect_pkg.sv
// Shared types and constants for the tone band detector: band FSM state
// encoding, counter widths and default parameter values.
package tone_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_RELEASING = 2'd3
  } band_state_e;

  localparam int CNT_W        = 8;
  localparam int ONSET_CNT_W  = 16;

  localparam int DEF_KW       = 10;
  localparam int DEF_NBANDS   = 4;
  localparam int DEF_HIT_CNT  = 3;
  localparam int DEF_MISS_CNT = 4;

endpackage

// File: rtl/tone_band_fsm.sv
// One detection band: bin-range hit test plus the IDLE/ARMING/ACTIVE/RELEASING
// debounce FSM with a registered detection flag.
module tone_band_fsm
  import tone_detect_pkg::*;
#(
  parameter int KW       = DEF_KW,
  parameter int HIT_CNT  = DEF_HIT_CNT,
  parameter int MISS_CNT = DEF_MISS_CNT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [KW-1:0] in_bin,
  input  logic [KW-1:0] band_lo,
  input  logic [KW-1:0] band_hi,
  input  logic          band_en,
  output logic          detected,
  output logic          onset_next
);

  localparam logic [CNT_W-1:0] HIT_LIM  = CNT_W'(HIT_CNT);
  localparam logic [CNT_W-1:0] MISS_LIM = CNT_W'(MISS_CNT);

  band_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             det_q;
  logic             hit;

  // An inverted range (lo > hi) can never satisfy both comparisons.
  assign hit     = band_en && (in_bin >= band_lo) && (in_bin <= band_hi);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!band_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (in_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            if (HIT_LIM <= CNT_W'(1)) begin
              state_d = ST_ACTIVE;
              cnt_d   = '0;
            end else begin
              state_d = ST_ARMING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_ARMING: begin
          if (!hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc >= HIT_LIM) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
        ST_ACTIVE: begin
          if (hit) begin
            cnt_d   = '0;
          end else if (MISS_LIM <= CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_RELEASING;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_RELEASING: begin
          if (hit) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
          end else if (cnt_inc >= MISS_LIM) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Onset only on entry from a non-detecting state; re-entry from RELEASING is silent.
  assign onset_next = (state_d == ST_ACTIVE) &&
                      ((state_q == ST_IDLE) || (state_q == ST_ARMING));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      det_q   <= (state_d == ST_ACTIVE) || (state_d == ST_RELEASING);
    end
  end

  assign detected = det_q;

endmodule

// File: rtl/tone_band_detect.sv
// Multi-band tone detector: NBANDS debounced bin-range detectors, onset pulse
// with lowest-index priority encoding. Optional per-band onset counters via TONE_ONSET_CNT_EN.
module tone_band_detect
  import tone_detect_pkg::*;
#(
  parameter int KW       = DEF_KW,
  parameter int NBANDS   = DEF_NBANDS,
  parameter int HIT_CNT  = DEF_HIT_CNT,
  parameter int MISS_CNT = DEF_MISS_CNT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [KW-1:0]          in_bin,
  input  logic [NBANDS*KW-1:0]   band_lo,
  input  logic [NBANDS*KW-1:0]   band_hi,
  input  logic [NBANDS-1:0]      band_en,
  output logic [NBANDS-1:0]      detected,
  output logic                   any_detected,
  output logic                   onset,
`ifdef TONE_ONSET_CNT_EN
  output logic [NBANDS*ONSET_CNT_W-1:0] onset_count,
`endif
  output logic [((NBANDS > 1) ? $clog2(NBANDS) : 1)-1:0] onset_band
);

  localparam int OBW = (NBANDS > 1) ? $clog2(NBANDS) : 1;

  logic [NBANDS-1:0] onset_next;
  logic              onset_q;
  logic [OBW-1:0]    onset_band_q, enc_d;

  for (genvar b = 0; b < NBANDS; b++) begin : g_band
    tone_band_fsm #(
      .KW       (KW),
      .HIT_CNT  (HIT_CNT),
      .MISS_CNT (MISS_CNT)
    ) u_fsm (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_bin     (in_bin),
      .band_lo    (band_lo[b*KW +: KW]),
      .band_hi    (band_hi[b*KW +: KW]),
      .band_en    (band_en[b]),
      .detected   (detected[b]),
      .onset_next (onset_next[b])
    );
  end

  always_comb begin
    enc_d = '0;
    for (int b = NBANDS - 1; b >= 0; b--) begin
      if (onset_next[b]) enc_d = OBW'(b);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      onset_q      <= 1'b0;
      onset_band_q <= '0;
    end else begin
      onset_q <= |onset_next;
      if (|onset_next) onset_band_q <= enc_d;
    end
  end

  assign onset        = onset_q;
  assign onset_band   = onset_band_q;
  assign any_detected = |detected;

`ifdef TONE_ONSET_CNT_EN
  logic [ONSET_CNT_W-1:0] ocnt_q [NBANDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NBANDS; b++) begin
      if (!reset_n) begin
        ocnt_q[b] <= '0;
      end else if (onset_next[b] && (ocnt_q[b] != {ONSET_CNT_W{1'b1}})) begin
        ocnt_q[b] <= ocnt_q[b] + ONSET_CNT_W'(1);
      end
    end
  end

  for (genvar b = 0; b < NBANDS; b++) begin : g_ocnt
    assign onset_count[b*ONSET_CNT_W +: ONSET_CNT_W] = ocnt_q[b];
  end
`endif

endmodule

// File: tb/tb_tone_band_detect.sv
// Scoreboard bench for tone_band_detect: directed bin sequences push expected
// outputs; a monitor pops and compares one cycle after each driven sample.
module tb_tone_band_detect;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [9:0]  in_bin;
  logic [39:0] band_lo, band_hi;
  logic [3:0]  band_en;
  logic [3:0]  detected;
  logic        any_detected, onset;
  logic [1:0]  onset_band;
`ifdef TONE_ONSET_CNT_EN
  logic [63:0] onset_count;
`endif

  always #5 clk = ~clk;

  tone_band_detect #(.KW(10), .NBANDS(4), .HIT_CNT(3), .MISS_CNT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_bin       (in_bin),
    .band_lo      (band_lo),
    .band_hi      (band_hi),
    .band_en      (band_en),
    .detected     (detected),
    .any_detected (any_detected),
    .onset        (onset),
`ifdef TONE_ONSET_CNT_EN
    .onset_count  (onset_count),
`endif
    .onset_band   (onset_band)
  );

  typedef struct {
    logic [3:0] det;
    logic       on;
    logic [1:0] band;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic chk = 1'b0;
  logic pend = 1'b0;

  always @(posedge clk) pend <= chk;

  always @(negedge clk) begin
    if (pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow: output cycle with no expected entry");
      end else begin
        exp_t e;
        logic [7:0] act, req;
        e   = exp_q.pop_front();
        act = {detected, any_detected, onset, onset_band};
        req = {e.det, |e.det, e.on, e.band};
        if (act !== req) begin
          errors++;
          $display("FAIL %s: got det=%b any=%b onset=%b band=%0d, expected det=%b any=%b onset=%b band=%0d",
                   e.nm, detected, any_detected, onset, onset_band, e.det, |e.det, e.on, e.band);
        end
      end
    end
  end

  task automatic step(input logic rn, input logic [3:0] en, input logic v,
                      input logic [9:0] bin, input logic [3:0] edet,
                      input logic eon, input logic [1:0] eb, input string nm);
    exp_t e;
    @(negedge clk);
    reset_n  = rn;
    band_en  = en;
    in_valid = v;
    in_bin   = bin;
    chk      = 1'b1;
    e.det = edet; e.on = eon; e.band = eb; e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Idle gap so band bounds only change while no sample is being taken.
  task automatic set_band(input int b, input logic [9:0] lo, input logic [9:0] hi);
    @(negedge clk);
    in_valid = 1'b0;
    chk      = 1'b0;
    band_lo[10*b +: 10] = lo;
    band_hi[10*b +: 10] = hi;
  endtask

  task automatic run(input logic [9:0] bin, input int n, input logic [3:0] edet, input string nm);
    for (int i = 0; i < n; i++) step(1'b1, 4'hF, 1'b1, bin, edet, 1'b0, 2'd0, nm);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_bin   = '0;
    band_en  = 4'hF;
    band_lo  = {10'd5, 10'd100, 10'd40, 10'd22};
    band_hi  = {10'd5, 10'd110, 10'd42, 10'd23};

    step(1'b0, 4'hF, 1'b1, 10'd22, 4'b0000, 1'b0, 2'd0, "reset_valid_ignored");
    step(1'b0, 4'hF, 1'b0, 10'd0,  4'b0000, 1'b0, 2'd0, "reset_idle");

    // three in-band samples on band 0
    step(1'b1, 4'hF, 1'b1, 10'd22, 4'b0000, 1'b0, 2'd0, "b0_hit1");
    step(1'b1, 4'hF, 1'b1, 10'd23, 4'b0000, 1'b0, 2'd0, "b0_hit2");
    step(1'b1, 4'hF, 1'b1, 10'd22, 4'b0001, 1'b1, 2'd0, "b0_onset");
    step(1'b1, 4'hF, 1'b0, 10'd0,  4'b0001, 1'b0, 2'd0, "b0_hold_novalid");

    // release with a hit after three misses restarting the miss run
    run(10'd50, 3, 4'b0001, "b0_releasing");
    step(1'b1, 4'hF, 1'b1, 10'd22, 4'b0001, 1'b0, 2'd0, "b0_rehit_no_onset");
    run(10'd50, 3, 4'b0001, "b0_releasing2");
    step(1'b1, 4'hF, 1'b1, 10'd50, 4'b0000, 1'b0, 2'd0, "b0_release");

    // broken arming run
    run(10'd22, 2, 4'b0000, "b0_arm");
    step(1'b1, 4'hF, 1'b1, 10'd50, 4'b0000, 1'b0, 2'd0, "b0_arm_break");
    run(10'd22, 2, 4'b0000, "b0_rearm");
    step(1'b1, 4'hF, 1'b1, 10'd22, 4'b0001, 1'b1, 2'd0, "b0_onset_after_break");
    run(10'd50, 3, 4'b0001, "b0_rel");
    step(1'b1, 4'hF, 1'b1, 10'd50, 4'b0000, 1'b0, 2'd0, "b0_rel_done");

    // inclusive bounds on band 2, then out-of-range neighbours
    step(1'b1, 4'hF, 1'b1, 10'd100, 4'b0000, 1'b0, 2'd0, "b2_lo_edge");
    step(1'b1, 4'hF, 1'b1, 10'd110, 4'b0000, 1'b0, 2'd0, "b2_hi_edge");
    step(1'b1, 4'hF, 1'b1, 10'd105, 4'b0100, 1'b1, 2'd2, "b2_onset");
    step(1'b1, 4'hF, 1'b1, 10'd99,  4'b0100, 1'b0, 2'd2, "b2_miss_99");
    step(1'b1, 4'hF, 1'b1, 10'd111, 4'b0100, 1'b0, 2'd2, "b2_miss_111");
    step(1'b1, 4'hF, 1'b1, 10'd21,  4'b0100, 1'b0, 2'd2, "b2_miss_21");
    step(1'b1, 4'hF, 1'b1, 10'd24,  4'b0000, 1'b0, 2'd2, "b2_release");

    // overlapping bands, simultaneous onset reports lowest index
    set_band(2, 10'd41, 10'd41);
    step(1'b1, 4'hF, 1'b1, 10'd41, 4'b0000, 1'b0, 2'd2, "ovl_hit1");
    step(1'b1, 4'hF, 1'b1, 10'd41, 4'b0000, 1'b0, 2'd2, "ovl_hit2");
    step(1'b1, 4'hF, 1'b1, 10'd41, 4'b0110, 1'b1, 2'd1, "ovl_onset");
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 1'b1, 10'd50, 4'b0110, 1'b0, 2'd1, "ovl_releasing");
    step(1'b1, 4'hF, 1'b1, 10'd50, 4'b0000, 1'b0, 2'd1, "ovl_release");

    // inverted range never hits
    set_band(1, 10'd42, 10'd40);
    set_band(2, 10'd100, 10'd110);
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 1'b1, 10'd41, 4'b0000, 1'b0, 2'd1, "inverted_range");
    set_band(1, 10'd40, 10'd42);

    // band 3 onset, then mid-arming reset
    step(1'b1, 4'hF, 1'b1, 10'd5, 4'b0000, 1'b0, 2'd1, "b3_hit1");
    step(1'b1, 4'hF, 1'b1, 10'd5, 4'b0000, 1'b0, 2'd1, "b3_hit2");
    step(1'b1, 4'hF, 1'b1, 10'd5, 4'b1000, 1'b1, 2'd3, "b3_onset");
    step(1'b1, 4'hF, 1'b0, 10'd0, 4'b1000, 1'b0, 2'd3, "b3_band_hold");
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 1'b1, 10'd50, 4'b1000, 1'b0, 2'd3, "b3_releasing");
    step(1'b1, 4'hF, 1'b1, 10'd50, 4'b0000, 1'b0, 2'd3, "b3_release");
    step(1'b1, 4'hF, 1'b1, 10'd22, 4'b0000, 1'b0, 2'd3, "pre_rst_hit1");
    step(1'b1, 4'hF, 1'b1, 10'd22, 4'b0000, 1'b0, 2'd3, "pre_rst_hit2");
    step(1'b0, 4'hF, 1'b1, 10'd22, 4'b0000, 1'b0, 2'd0, "mid_reset");
    step(1'b1, 4'hF, 1'b1, 10'd22, 4'b0000, 1'b0, 2'd0, "post_rst_hit1");
    step(1'b1, 4'hF, 1'b1, 10'd22, 4'b0000, 1'b0, 2'd0, "post_rst_hit2");
    step(1'b1, 4'hF, 1'b1, 10'd22, 4'b0001, 1'b1, 2'd0, "post_rst_onset");

    // enable drop clears without onset
    step(1'b1, 4'b1110, 1'b1, 10'd22, 4'b0000, 1'b0, 2'd0, "b0_disable");
    step(1'b1, 4'hF,    1'b1, 10'd22, 4'b0000, 1'b0, 2'd0, "b0_reenable_arm");
    step(1'b1, 4'hF, 1'b1, 10'd5, 4'b0000, 1'b0, 2'd0, "b3_again1");
    step(1'b1, 4'hF, 1'b1, 10'd5, 4'b0000, 1'b0, 2'd0, "b3_again2");
    step(1'b1, 4'hF, 1'b1, 10'd5, 4'b1000, 1'b1, 2'd3, "b3_again_onset");
    step(1'b1, 4'b0111, 1'b0, 10'd0, 4'b0000, 1'b0, 2'd3, "b3_disable_novalid");
    step(1'b1, 4'hF,    1'b0, 10'd0, 4'b0000, 1'b0, 2'd3, "b3_reenable");

    @(negedge clk);
    chk      = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
`ifdef TONE_ONSET_CNT_EN
    checks++;
    if (onset_count[48 +: 16] !== 16'd1) begin
      errors++;
      $display("FAIL onset_count3: got %0d, expected 1", onset_count[48 +: 16]);
    end
    checks++;
    if (onset_count[0 +: 16] !== 16'd1) begin
      errors++;
      $display("FAIL onset_count0: got %0d, expected 1", onset_count[0 +: 16]);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
